// File: rtl/conv1d_obi_fetch.sv
// conv1d OBI fetch: pipelined word reads from system memory into the SRAM buffer.
// Optional CONV1D_FETCH_PERF_EN adds stall_cnt_o (cycles with req && !gnt).
module conv1d_obi_fetch #(
  parameter int unsigned NumWords = 128,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned AW = $clog2(NumWords)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [31:0]   src_addr_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic [7:0]    len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          obi_req_o,
  input  logic          obi_gnt_i,
  output logic [31:0]   obi_addr_o,
  output logic          obi_we_o,
  output logic [3:0]    obi_be_o,
  output logic [31:0]   obi_wdata_o,
  input  logic          obi_rvalid_i,
  input  logic [31:0]   obi_rdata_i,
  output logic          sram_req_o,
  output logic          sram_we_o,
  output logic [3:0]    sram_be_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o
`ifdef CONV1D_FETCH_PERF_EN
  ,
  output logic [15:0]   stall_cnt_o
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] MaxOut = 4'(MaxOutstanding);

  logic [1:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    issued_q, issued_d;
  logic [7:0]    received_q, received_d;
  logic [3:0]    outst_q, outst_d;
  logic [31:0]   src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic          sram_req_q, sram_req_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;

  logic start_ok;
  logic req;
  logic grant;
  logic resp;

  assign start_ok = start_i && (state_q == S_IDLE);
  // Condition can only stay true until granted, so req/addr are stable
  assign req   = (state_q == S_RUN) && (issued_q < len_q)
               && (outst_q < MaxOut);
  assign grant = req && obi_gnt_i;
  assign resp  = obi_rvalid_i && (outst_q != 4'd0);

  always_comb begin
    len_d        = len_q;
    src_d        = src_q;
    dst_d        = dst_q;
    issued_d     = issued_q;
    received_d   = received_q;
    outst_d      = outst_q;
    sram_req_d   = resp;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (start_ok) begin
      len_d      = len_i;
      src_d      = src_addr_i;
      dst_d      = dst_addr_i;
      issued_d   = 8'd0;
      received_d = 8'd0;
      outst_d    = 4'd0;
    end else begin
      if (grant) issued_d = issued_q + 8'd1;
      if (resp) received_d = received_q + 8'd1;
      if (grant && !resp) outst_d = outst_q + 4'd1;
      if (!grant && resp) outst_d = outst_q - 4'd1;
    end
    if (resp) begin
      sram_addr_d  = dst_q + AW'(received_q);
      sram_wdata_d = obi_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok)
          state_d = (len_i == 8'd0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (issued_d == len_q)
          state_d = (received_d == len_q) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (received_d == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      issued_q     <= '0;
      received_q   <= '0;
      outst_q      <= '0;
      sram_req_q   <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      issued_q     <= issued_d;
      received_q   <= received_d;
      outst_q      <= outst_d;
      sram_req_q   <= sram_req_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign obi_req_o    = req;
  assign obi_addr_o   = (src_q & 32'hFFFF_FFFC)
                      + {22'd0, issued_q, 2'b00};
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = 4'hF;
  assign obi_wdata_o  = 32'd0;
  assign sram_req_o   = sram_req_q;
  assign sram_we_o    = sram_req_q;
  assign sram_be_o    = 4'hF;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;

`ifdef CONV1D_FETCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok)
      stall_d = 16'd0;
    else if (req && !obi_gnt_i && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

`ifndef SYNTHESIS
  // A response with nothing outstanding during a transfer is a subordinate bug
  a_rvalid_outst: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (obi_rvalid_i && busy_o) |-> (outst_q != 4'd0));
`endif

endmodule

// File: tb/tb_conv1d_obi_fetch.sv
// Directed bench for conv1d_obi_fetch with an in-order OBI subordinate model.
// Memory word at byte address a reads as a ^ 32'hA5A5_0000.
module tb_conv1d_obi_fetch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] src_addr_i;
  logic [6:0]  dst_addr_i;
  logic [7:0]  len_i;
  logic        busy_o;
  logic        done_o;
  logic        obi_req_o;
  logic        obi_gnt_i;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid_i;
  logic [31:0] obi_rdata_i;
  logic        sram_req_o;
  logic        sram_we_o;
  logic [3:0]  sram_be_o;
  logic [6:0]  sram_addr_o;
  logic [31:0] sram_wdata_o;
`ifdef CONV1D_FETCH_PERF_EN
  logic [15:0] stall_cnt_o;
`endif

  conv1d_obi_fetch dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_rdata_i  (obi_rdata_i),
    .sram_req_o   (sram_req_o),
    .sram_we_o    (sram_we_o),
    .sram_be_o    (sram_be_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o)
`ifdef CONV1D_FETCH_PERF_EN
    ,
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] pend_q[$];
  logic [31:0] gaddr[$];
  logic [6:0]  waddr[$];
  logic [31:0] wdata[$];
  int done_cnt;
  int done_idx;
  int stall_seen;
  int stab_err;
  int req_seen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic clear_logs();
    gaddr.delete();
    waddr.delete();
    wdata.delete();
    done_cnt   = 0;
    done_idx   = -1;
    stall_seen = 0;
    stab_err   = 0;
    req_seen   = 0;
  endtask

  task automatic start(input logic [31:0] src, input logic [6:0] dst,
                       input logic [7:0] len);
    src_addr_i   = src;
    dst_addr_i   = dst;
    len_i        = len;
    start_i      = 1'b1;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Subordinate: gnt low for the first gnt_lo request cycles,
  // rvalid withheld for the first hold cycles, one response per cycle.
  task automatic run(input int max_cyc, input int gnt_lo, input int hold);
    logic        prev_stall;
    logic [31:0] prev_addr;
    int          nreq;
    bit          saw;
    prev_stall = 1'b0;
    prev_addr  = '0;
    nreq       = 0;
    for (int i = 0; i < max_cyc; i++) begin
      saw          = 1'b0;
      obi_rvalid_i = 1'b0;
      obi_rdata_i  = '0;
      if (i >= hold && pend_q.size() > 0) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = mem_word(pend_q.pop_front());
      end
      obi_gnt_i = (nreq >= gnt_lo);
      if (prev_stall && (!obi_req_o || obi_addr_o !== prev_addr))
        stab_err++;
      if (obi_req_o) begin
        req_seen++;
        nreq++;
        if (obi_gnt_i) begin
          pend_q.push_back(obi_addr_o);
          gaddr.push_back(obi_addr_o);
        end else begin
          stall_seen++;
        end
      end
      prev_stall = obi_req_o && !obi_gnt_i;
      prev_addr  = obi_addr_o;
      if (sram_req_o) begin
        waddr.push_back(sram_addr_o);
        wdata.push_back(sram_wdata_o);
      end
      if (done_o) begin
        done_cnt++;
        done_idx = i;
        saw = 1'b1;
      end
      @(posedge clk_i); #1;
      if (saw) break;
    end
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    src_addr_i = '0;
    dst_addr_i = '0;
    len_i = '0;
    obi_gnt_i = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, obi_req_o, obi_we_o, sram_req_o, sram_we_o} !== 6'b0) begin
      errors++;
      $display("FAIL rst_ctl got %b exp 000000",
               {busy_o, done_o, obi_req_o, obi_we_o, sram_req_o, sram_we_o});
    end
    checks++;
    if ({obi_be_o, sram_be_o} !== 8'hFF) begin
      errors++;
      $display("FAIL rst_be got %h exp ff", {obi_be_o, sram_be_o});
    end
    checks++;
    if ({obi_addr_o, obi_wdata_o, sram_wdata_o} !== 96'd0 || sram_addr_o !== 7'd0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h %h exp 0",
               obi_addr_o, obi_wdata_o, sram_wdata_o, sram_addr_o);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    start(32'h1000_0000, 7'd0, 8'd4);
    run(40, 0, 0);
    checks++;
    if (gaddr.size() != 4 || gaddr[0] !== 32'h1000_0000 || gaddr[1] !== 32'h1000_0004
        || gaddr[2] !== 32'h1000_0008 || gaddr[3] !== 32'h1000_000C) begin
      errors++;
      $display("FAIL basic_addr got n=%0d last %h exp 4 1000000c",
               gaddr.size(), gaddr.size() > 0 ? gaddr[gaddr.size()-1] : 32'h0);
    end
    checks++;
    if (waddr.size() != 4 || waddr[0] !== 7'd0 || waddr[3] !== 7'd3
        || wdata[0] !== 32'hB5A5_0000 || wdata[3] !== 32'hB5A5_000C) begin
      errors++;
      $display("FAIL basic_sram got n=%0d exp 4 writes 0..3", waddr.size());
    end
    checks++;
    if (done_cnt != 1 || done_idx != 5) begin
      errors++;
      $display("FAIL basic_done got cnt=%0d idx=%0d exp 1 5", done_cnt, done_idx);
    end
  endtask

  task automatic test_min_latency();
    clear_logs();
    start(32'h0000_0000, 7'd5, 8'd1);
    run(20, 0, 0);
    checks++;
    if (done_idx != 2 || done_cnt != 1) begin
      errors++;
      $display("FAIL lat_done got idx=%0d cnt=%0d exp 2 1", done_idx, done_cnt);
    end
    checks++;
    if (waddr.size() != 1 || waddr[0] !== 7'd5 || wdata[0] !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL lat_sram got n=%0d exp 1 write 05 a5a50000", waddr.size());
    end
  endtask

  task automatic test_outstanding();
    clear_logs();
    start(32'h2000_0000, 7'd8, 8'd8);
    run(10, 0, 100);
    checks++;
    if (gaddr.size() != 4 || obi_req_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL outst_limit got grants=%0d req=%b busy=%b exp 4 0 1",
               gaddr.size(), obi_req_o, busy_o);
    end
    run(40, 0, 0);
    checks++;
    if (gaddr.size() != 8 || gaddr[4] !== 32'h2000_0010 || gaddr[7] !== 32'h2000_001C) begin
      errors++;
      $display("FAIL outst_addr got n=%0d exp 8 grants 20000010..1c", gaddr.size());
    end
    checks++;
    if (waddr.size() != 8 || waddr[7] !== 7'd15 || wdata[7] !== 32'h85A5_001C
        || done_cnt != 1) begin
      errors++;
      $display("FAIL outst_sram got n=%0d done=%0d exp 8 1", waddr.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    start(32'h3000_0006, 7'd126, 8'd4);
    run(40, 0, 0);
    checks++;
    if (gaddr.size() != 4 || gaddr[0] !== 32'h3000_0004) begin
      errors++;
      $display("FAIL wrap_src got n=%0d exp 4 first 30000004", gaddr.size());
    end
    checks++;
    if (waddr.size() != 4 || waddr[0] !== 7'd126 || waddr[1] !== 7'd127
        || waddr[2] !== 7'd0 || waddr[3] !== 7'd1 || wdata[2] !== 32'h95A5_000C) begin
      errors++;
      $display("FAIL wrap_sram got n=%0d exp 126 127 0 1", waddr.size());
    end
    clear_logs();
    start(32'hFFFF_FFF8, 7'd16, 8'd4);
    run(40, 0, 0);
    checks++;
    if (gaddr.size() != 4 || gaddr[1] !== 32'hFFFF_FFFC || gaddr[2] !== 32'h0000_0000
        || gaddr[3] !== 32'h0000_0004 || wdata[2] !== 32'hA5A5_0000) begin
      errors++;
      $display("FAIL addr_ovf got n=%0d exp fffffff8 fffffffc 0 4", gaddr.size());
    end
  endtask

  task automatic test_zero_len_and_busy_start();
    clear_logs();
    start(32'h6000_0000, 7'd0, 8'd0);
    run(6, 0, 0);
    checks++;
    if (done_cnt != 1 || done_idx != 0 || req_seen != 0) begin
      errors++;
      $display("FAIL zero_len got done=%0d idx=%0d reqs=%0d exp 1 0 0",
               done_cnt, done_idx, req_seen);
    end
    clear_logs();
    start(32'h7000_0000, 7'd0, 8'd2);
    start(32'h7100_0000, 7'd64, 8'd5);
    run(40, 0, 0);
    checks++;
    if (gaddr.size() != 2 || gaddr[1] !== 32'h7000_0004 || done_cnt != 1
        || waddr.size() != 2 || waddr[1] !== 7'd1) begin
      errors++;
      $display("FAIL busy_start got grants=%0d done=%0d exp 2 1", gaddr.size(), done_cnt);
    end
  endtask

  task automatic test_stall();
    clear_logs();
    start(32'h4000_0000, 7'd0, 8'd2);
    run(40, 3, 0);
    checks++;
    if (stall_seen != 3 || stab_err != 0 || gaddr.size() != 2
        || gaddr[0] !== 32'h4000_0000 || done_cnt != 1) begin
      errors++;
      $display("FAIL stall got stalls=%0d unstable=%0d grants=%0d exp 3 0 2",
               stall_seen, stab_err, gaddr.size());
    end
`ifdef CONV1D_FETCH_PERF_EN
    checks++;
    if (stall_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt got %0d exp 3", stall_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_logs();
    start(32'h5000_0000, 7'd0, 8'd8);
    run(2, 0, 100);
    checks++;
    if (gaddr.size() != 2 || pend_q.size() != 2) begin
      errors++;
      $display("FAIL rstmid_pre got grants=%0d exp 2", gaddr.size());
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run(4, 0, 0);
    checks++;
    if (waddr.size() != 0 || done_cnt != 0 || busy_o !== 1'b0
        || pend_q.size() != 0 || req_seen != 2) begin
      errors++;
      $display("FAIL rstmid got writes=%0d done=%0d busy=%b reqs=%0d exp 0 0 0 2",
               waddr.size(), done_cnt, busy_o, req_seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_latency();
    test_outstanding();
    test_wrap();
    test_zero_len_and_busy_start();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
